// File: rtl/gnrl_defs.sv
// Shared definitions for the SRAM arbitration controller: FSM state encoding
// and requester indices.
package gnrl_defs;

  typedef enum logic {
    SRAM_ARB_CLEAR = 1'b0,
    SRAM_ARB_SERVE = 1'b1
  } sram_arb_state_e;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

endpackage

// File: rtl/gnrl_rr_arb2.sv
// Two-way round-robin arbiter: on conflict the requester not granted last wins.
// The pointer moves only when a grant is issued.
module gnrl_rr_arb2
  import gnrl_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  logic last_q;
  logic last_d;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (i_valid == 2'b11) begin
        o_grant = (last_q == 1'b1) ? 2'b01 : 2'b10;
      end else begin
        o_grant = i_valid;
      end
    end
    last_d = last_q;
    if (o_grant[REQ0]) begin
      last_d = 1'b0;
    end else if (o_grant[REQ1]) begin
      last_d = 1'b1;
    end
  end

  // Pointer starts at requester 1 so requester 0 wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Shares one single-port SRAM between two requesters and clears the table after
// reset/flush. Define SRAM_ARB_FIXED_PRIO_EN for fixed requester-0 priority.
module sram_arb_ctrl
  import gnrl_defs::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    SRAM_DEPTH    = 128,
  parameter int                    ADDR_WIDTH    = $clog2(SRAM_DEPTH),
  parameter int                    CLEAR_ENABLE  = 1,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  output logic                  o_busy,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_wren,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_din,
  output logic                  o_req0_rvalid,
  output logic [DATA_WIDTH-1:0] o_req0_rdata,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_wren,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_din,
  output logic                  o_req1_rvalid,
  output logic [DATA_WIDTH-1:0] o_req1_rdata,
  output logic                  o_sram_cs,
  output logic                  o_sram_wren,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_din,
  input  logic [DATA_WIDTH-1:0] i_sram_dout
);

  localparam sram_arb_state_e RST_STATE = (CLEAR_ENABLE != 0) ? SRAM_ARB_CLEAR : SRAM_ARB_SERVE;
  // One extra counter bit keeps the last-entry compare unambiguous for power-of-two depths.
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(SRAM_DEPTH - 1);

  sram_arb_state_e       state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic                  busy_q, busy_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic       flush_en;
  logic       arb_en;
  logic [1:0] req_valid;
  logic [1:0] grant;

  assign flush_en  = (CLEAR_ENABLE != 0) && i_flush;
  assign arb_en    = (state_q == SRAM_ARB_SERVE) && !flush_en;
  assign req_valid = {i_req1_valid, i_req0_valid};

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign grant = arb_en ? {req_valid[REQ1] & ~req_valid[REQ0], req_valid[REQ0]} : 2'b00;
`else
  gnrl_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_en    (arb_en),
    .i_valid (req_valid),
    .o_grant (grant)
  );
`endif

  assign o_req0_ready  = grant[REQ0];
  assign o_req1_ready  = grant[REQ1];
  assign o_busy        = busy_q;
  assign o_req0_rvalid = rvalid0_q;
  assign o_req1_rvalid = rvalid1_q;
  assign o_req0_rdata  = rdata0_q;
  assign o_req1_rdata  = rdata1_q;

  always_comb begin
    o_sram_cs   = 1'b0;
    o_sram_wren = 1'b0;
    o_sram_addr = '0;
    o_sram_din  = '0;
    if (state_q == SRAM_ARB_CLEAR) begin
      o_sram_cs   = 1'b1;
      o_sram_wren = 1'b1;
      o_sram_addr = clr_cnt_q[ADDR_WIDTH-1:0];
      o_sram_din  = INITIAL_VALUE;
    end else if (grant[REQ0]) begin
      o_sram_cs   = 1'b1;
      o_sram_wren = i_req0_wren;
      o_sram_addr = i_req0_addr;
      o_sram_din  = i_req0_din;
    end else if (grant[REQ1]) begin
      o_sram_cs   = 1'b1;
      o_sram_wren = i_req1_wren;
      o_sram_addr = i_req1_addr;
      o_sram_din  = i_req1_din;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      SRAM_ARB_CLEAR: begin
        if (flush_en) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == LAST_IDX) begin
          state_d   = SRAM_ARB_SERVE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        if (flush_en) begin
          state_d   = SRAM_ARB_CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
    busy_d = (state_d == SRAM_ARB_CLEAR);

    // Read data is captured from the combinational SRAM output in the grant cycle.
    rvalid0_d = grant[REQ0] & ~i_req0_wren;
    rvalid1_d = grant[REQ1] & ~i_req1_wren;
    rdata0_d  = rvalid0_d ? i_sram_dout : rdata0_q;
    rdata1_d  = rvalid1_d ? i_sram_dout : rdata1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      busy_q    <= (CLEAR_ENABLE != 0);
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl: one clearing instance backed by an SRAM model
// and one instance built without the clear sequence.
module tb_sram_arb_ctrl;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam logic [DW-1:0] INIT = 32'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic          flush;
  logic          busy;
  logic          v0, w0, rdy0, rv0;
  logic [AW-1:0] a0;
  logic [DW-1:0] d0, rd0;
  logic          v1, w1, rdy1, rv1;
  logic [AW-1:0] a1;
  logic [DW-1:0] d1, rd1;
  logic          cs, wren;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, dout;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (cs && wren) mem[addr] <= din;
  assign dout = mem[addr];

  sram_arb_ctrl #(
    .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .CLEAR_ENABLE(1), .INITIAL_VALUE(INIT)
  ) u_dut (
    .clk(clk), .rst(rst), .i_flush(flush), .o_busy(busy),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_wren(w0), .i_req0_addr(a0),
    .i_req0_din(d0), .o_req0_rvalid(rv0), .o_req0_rdata(rd0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_wren(w1), .i_req1_addr(a1),
    .i_req1_din(d1), .o_req1_rvalid(rv1), .o_req1_rdata(rd1),
    .o_sram_cs(cs), .o_sram_wren(wren), .o_sram_addr(addr), .o_sram_din(din),
    .i_sram_dout(dout)
  );

  logic          nc_flush, nc_busy;
  logic          nc_v0, nc_w0, nc_rdy0, nc_rv0;
  logic [AW-1:0] nc_a0;
  logic [DW-1:0] nc_d0, nc_rd0;
  logic          nc_v1, nc_w1, nc_rdy1, nc_rv1;
  logic [AW-1:0] nc_a1;
  logic [DW-1:0] nc_d1, nc_rd1;
  logic          nc_cs, nc_wren;
  logic [AW-1:0] nc_addr;
  logic [DW-1:0] nc_din;
  logic [DW-1:0] nc_dout;
  logic          nc_busy_seen = 1'b0;
  assign nc_dout = 32'hC0DE;
  always @(posedge clk) if (nc_busy) nc_busy_seen <= 1'b1;

  sram_arb_ctrl #(
    .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .CLEAR_ENABLE(0), .INITIAL_VALUE(INIT)
  ) u_dut_nc (
    .clk(clk), .rst(rst), .i_flush(nc_flush), .o_busy(nc_busy),
    .i_req0_valid(nc_v0), .o_req0_ready(nc_rdy0), .i_req0_wren(nc_w0), .i_req0_addr(nc_a0),
    .i_req0_din(nc_d0), .o_req0_rvalid(nc_rv0), .o_req0_rdata(nc_rd0),
    .i_req1_valid(nc_v1), .o_req1_ready(nc_rdy1), .i_req1_wren(nc_w1), .i_req1_addr(nc_a1),
    .i_req1_din(nc_d1), .o_req1_rvalid(nc_rv1), .o_req1_rdata(nc_rd1),
    .o_sram_cs(nc_cs), .o_sram_wren(nc_wren), .o_sram_addr(nc_addr), .o_sram_din(nc_din),
    .i_sram_dout(nc_dout)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
  endtask

  // Checks one full clear pass starting at address 0, then the return to serve.
  task automatic check_clear(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_cs_wren"}, {30'd0, cs, wren}, 32'd3);
      chk({tag, "_addr"}, {29'd0, addr}, i);
      chk({tag, "_din"}, din, INIT);
      chk({tag, "_rdy"}, {30'd0, rdy1, rdy0}, 32'd0);
      step();
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  logic exp0;

  initial begin
    idle_inputs();
    nc_flush = 1'b0;
    nc_v0 = 1'b0; nc_w0 = 1'b0; nc_a0 = '0; nc_d0 = '0;
    nc_v1 = 1'b0; nc_w1 = 1'b0; nc_a1 = '0; nc_d1 = '0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rvalid", {30'd0, rv1, rv0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_rdata1", rd1, 32'd0);
    chk("rst_addr", {29'd0, addr}, 32'd0);
    chk("nc_rst_busy", {31'd0, nc_busy}, 32'd0);
    rst = 1'b0;
    check_clear("clr0");

    // req0 reads addr 3 after the clear
    v0 = 1'b1; w0 = 1'b0; a0 = 3'd3;
    #1;
    chk("rd3_ready0", {31'd0, rdy0}, 32'd1);
    chk("rd3_cs", {30'd0, cs, wren}, 32'd2);
    chk("rd3_addr", {29'd0, addr}, 32'd3);
    step();
    v0 = 1'b0;
    chk("rd3_rvalid0", {31'd0, rv0}, 32'd1);
    chk("rd3_rdata0", rd0, INIT);
    step();
    chk("rd3_pulse", {31'd0, rv0}, 32'd0);
    chk("rd3_hold", rd0, INIT);

    // req0 writes addr 2 then reads it back
    v0 = 1'b1; w0 = 1'b1; a0 = 3'd2; d0 = 32'h1234;
    #1;
    chk("wr2_ready0", {31'd0, rdy0}, 32'd1);
    chk("wr2_din", din, 32'h1234);
    step();
    chk("wr2_no_rvalid", {30'd0, rv1, rv0}, 32'd0);
    w0 = 1'b0;
    step();
    v0 = 1'b0;
    chk("rd2_rvalid0", {31'd0, rv0}, 32'd1);
    chk("rd2_rdata0", rd0, 32'h1234);
    chk("rd2_rvalid1", {31'd0, rv1}, 32'd0);
    step();

    // req1 writes addr 5 so the pointer points at requester 1
    v1 = 1'b1; w1 = 1'b1; a1 = 3'd5; d1 = 32'hBEEF;
    #1;
    chk("wr5_ready1", {30'd0, rdy1, rdy0}, 32'd2);
    step();
    v1 = 1'b0; w1 = 1'b0;
    chk("wr5_mem", mem[5], 32'hBEEF);

    // both requesters read for 4 cycles
    v0 = 1'b1; a0 = 3'd1;
    v1 = 1'b1; a1 = 3'd2;
    for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = (k % 2 == 0);
`endif
      #1;
      chk("both_ready", {30'd0, rdy1, rdy0}, {30'd0, ~exp0, exp0});
      step();
      chk("both_rvalid", {30'd0, rv1, rv0}, {30'd0, ~exp0, exp0});
      if (exp0) chk("both_rdata0", rd0, INIT);
      else      chk("both_rdata1", rd1, 32'h1234);
    end
    v1 = 1'b0;

    // req0 read in flight, then flush while req1 is valid
    a0 = 3'd2;
    step();
    v0 = 1'b0;
    v1 = 1'b1; a1 = 3'd5; flush = 1'b1;
    #1;
    chk("fl_ready1", {30'd0, rdy1, rdy0}, 32'd0);
    chk("fl_cs", {31'd0, cs}, 32'd0);
    chk("fl_prev_rvalid0", {31'd0, rv0}, 32'd1);
    chk("fl_prev_rdata0", rd0, 32'h1234);
    step();
    flush = 1'b0; v1 = 1'b0;
    chk("fl_rvalid1", {31'd0, rv1}, 32'd0);
    check_clear("clr1");

    for (int i = 0; i < DEPTH; i++) begin
      v1 = 1'b1; w1 = 1'b0; a1 = AW'(i);
      step();
      chk("post_fl_rvalid1", {31'd0, rv1}, 32'd1);
      chk("post_fl_rdata1", rd1, INIT);
    end
    v1 = 1'b0;

    // flush at clr_cnt 5 restarts the clear
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #1;
    chk("fl5_addr", {29'd0, addr}, 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_clear("clr2");

    // reset at clr_cnt 3 restarts the clear from 0
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("rs3_addr", {29'd0, addr}, 32'd3);
    rst = 1'b1;
    #1;
    chk("rs3_async_addr", {29'd0, addr}, 32'd0);
    chk("rs3_async_busy", {31'd0, busy}, 32'd1);
    nc_v0 = 1'b1; nc_w0 = 1'b0; nc_a0 = 3'd4;
    step();
    rst = 1'b0;
    #1;
    chk("nc_first_ready0", {31'd0, nc_rdy0}, 32'd1);
    chk("nc_first_busy", {31'd0, nc_busy}, 32'd0);
    check_clear("clr3");
    chk("nc_rdata0", nc_rd0, 32'hC0DE);

    // first conflict after reset goes to requester 0
    v0 = 1'b1; a0 = 3'd0; v1 = 1'b1; a1 = 3'd1;
    #1;
    chk("rst_ptr_ready", {30'd0, rdy1, rdy0}, 32'd1);
    step();
    v0 = 1'b0; v1 = 1'b0;

    // no-clear instance ignores flush
    nc_v0 = 1'b0;
    nc_v1 = 1'b1; nc_w1 = 1'b1; nc_a1 = 3'd6; nc_flush = 1'b1;
    #1;
    chk("nc_flush_ready1", {31'd0, nc_rdy1}, 32'd1);
    chk("nc_flush_cs", {31'd0, nc_cs}, 32'd1);
    step();
    nc_v1 = 1'b0; nc_flush = 1'b0;
    chk("nc_after_flush_busy", {31'd0, nc_busy}, 32'd0);
    step();
    chk("nc_busy_never", {31'd0, nc_busy_seen}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
